// File: rtl/adder_pkg.sv
// Shared definitions for the frame accumulator datapath: FSM state
// encoding and default widths.
package adder_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int DEF_ACC_W = 8;
  localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/ripple_add_n.sv
// N-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
// Carry-in is tied low; the carry-out of the top cell is exported.
module ripple_add_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/frame_accumulator.sv
// Frame accumulator: sums 4-bit operands of a frame into an ACC_W-bit
// accumulator and presents one result (sum, beat count, overflow) per frame.
// Build option FRAME_ACC_SATURATE_EN: when defined, the accumulator clamps at
// its maximum on carry instead of wrapping. Port list is the same either way.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in progress, waiting for the first beat
// ACCUM | frame in progress, accumulating beats until in_last
// HOLD  | frame result presented on out_*, waiting for out_ready
module frame_accumulator
  import adder_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             ready_q;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic             accept;
  logic             take;

  // in_ready is registered so it stays low for the first cycle after reset.
  assign in_ready  = ready_q;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & ready_q;
  assign take      = out_valid & out_ready;

  ripple_add_n #(
    .N (ACC_W)
  ) u_add (
    .a    (acc),
    .b    ({{(ACC_W - 4){1'b0}}, in_data}),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next accumulator, counter and overflow values for an accepted beat.
  always_comb begin
`ifdef FRAME_ACC_SATURATE_EN
    // Once clamped, adding to the all-ones value carries again (or adds 0),
    // so the clamp holds for the rest of the frame.
    acc_nxt = add_cout ? {ACC_W{1'b1}} : add_sum;
`else
    acc_nxt = add_sum;
`endif
    ovf_nxt = ovf | add_cout;
    cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  end

  // Frame sequencing: accumulate until in_last, then hold the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != HOLD);
      if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
        if (in_last) begin
          out_sum <= acc_nxt;
          out_cnt <= cnt_nxt;
          out_ovf <= ovf_nxt;
        end
      end else if (take) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Self-checking bench for frame_accumulator: directed frames plus random
// frames, with results predicted from whole-frame arithmetic and compared
// by an independent monitor as the DUT hands them over.
module tb_frame_accumulator;

  localparam int ACC_W = 8;
  localparam int CNT_W = 5;
  localparam int MAX_SUM = (1 << ACC_W) - 1;
  localparam int MAX_CNT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_total = 0;
  int   m_beats = 0;
  bit   rand_ready = 0;

  frame_accumulator #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result of a frame from its total and beat count.
  function automatic res_t frame_result(input int total, input int beats);
    res_t r;
    r.ovf = (total > MAX_SUM) ? 1 : 0;
`ifdef FRAME_ACC_SATURATE_EN
    r.sum = (total > MAX_SUM) ? MAX_SUM : total;
`else
    r.sum = total % (MAX_SUM + 1);
`endif
    r.cnt = (beats > MAX_CNT) ? MAX_CNT : beats;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [3:0] d, input bit last);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready) begin
      step();
      w++;
      if (w > 300) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    step();
    m_total += int'(d);
    m_beats++;
    if (last) begin
      exp_q.push_back(frame_result(m_total, m_beats));
      m_total = 0;
      m_beats = 0;
      check("valid_after_last", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    in_data  = 4'($urandom_range(0, 15));
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int len, input logic [3:0] d);
    for (int i = 0; i < len; i++) begin
      send_beat(d, i == len - 1);
    end
  endtask

  // Monitor: compares every taken result against the scoreboard head.
  initial begin
    bit   prev_take;
    res_t e;
    prev_take = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_take = 0;
      end else begin
        if (prev_take) begin
          check("valid_drop_after_take", int'(out_valid), 0);
        end
        prev_take = out_valid && out_ready;
        if (prev_take) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_sum", int'(out_sum), e.sum);
            check("out_cnt", int'(out_cnt), e.cnt);
            check("out_ovf", int'(out_ovf), e.ovf);
          end
        end
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    res_t hold_exp;
    int   w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    repeat (3) step();
    rst = 1'b0;
    check("in_ready_before_first_edge", int'(in_ready), 0);
    step();
    check("in_ready_after_first_edge", int'(in_ready), 1);
    check("out_valid_idle", int'(out_valid), 0);

    // Basic frame 3, 5, 9.
    send_beat(4'h3, 1'b0);
    send_beat(4'h5, 1'b0);
    send_beat(4'h9, 1'b1);
    step();

    // Boundary: 17 x 0xF fits, 18 x 0xF overflows.
    send_frame(17, 4'hF);
    send_frame(18, 4'hF);

    // Single-beat frames back to back.
    send_beat(4'h7, 1'b1);
    send_beat(4'h2, 1'b1);
    step();

    // Backpressure in HOLD.
    out_ready = 1'b0;
    send_frame(3, 4'h6);
    hold_exp = exp_q[exp_q.size() - 1];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom_range(1, 15));
      in_last  = 1'($urandom_range(0, 1));
      step();
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_sum", int'(out_sum), hold_exp.sum);
      check("hold_out_cnt", int'(out_cnt), hold_exp.cnt);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);

    // Reset mid-frame discards the partial sum.
    send_beat(4'h4, 1'b0);
    send_beat(4'h4, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_sum", int'(out_sum), 0);
    check("midrst_out_cnt", int'(out_cnt), 0);
    check("midrst_out_ovf", int'(out_ovf), 0);
    m_total = 0;
    m_beats = 0;
    step();
    step();
    rst = 1'b0;
    step();
    send_beat(4'h1, 1'b1);
    step();

    // Beat counter saturation.
    send_frame(40, 4'h0);
    step();

    // Random frames with random gaps and random backpressure.
    rand_ready = 1;
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) step();
        end
        send_beat(4'($urandom_range(0, 15)), b == len - 1);
      end
    end
    rand_ready = 0;
    out_ready  = 1'b1;

    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      step();
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_accumulator.md
Name: frame_accumulator

Overview:
- Downstream consumer of the 4-bit ripple adder datapath. Sums a stream of 4-bit operands, delimited into frames, into a wider accumulator.
- Input side: valid/ready handshake, one operand per beat.
- Output side: one valid/ready result per frame, carrying the sum, beat count and overflow flag.
- Feeds result-reporting logic; in the datapath it sits between operand sources and the result bus.

Parameters:
- ACC_W, 8, accumulator and result width in bits. Legal range 5..16.
- CNT_W, 5, beat-counter width in bits.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  4  unsigned operand
- in_last  input  1  beat is the final beat of its frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  ACC_W  frame sum
- out_cnt  output  CNT_W  beats in the frame
- out_ovf  output  1  sum exceeded 2^ACC_W-1 during the frame

Behaviour:
- Reset: asynchronous, active-high. While rst=1 and after release:
  - state=IDLE, acc=0, cnt=0, ovf=0
  - in_ready=0 while rst=1; in_ready=1 from the first clk edge after release
  - out_valid=0, out_sum=0, out_cnt=0, out_ovf=0
- Reset mid-frame or mid-HOLD discards all partial or held data. No result is emitted.
- A beat is accepted when in_valid & in_ready. A result is taken when out_valid & out_ready.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1. Accepted beat, in_last=0 -> ACCUM. Accepted beat, in_last=1 -> HOLD.
  - ACCUM: in_ready=1. Accepted beat, in_last=1 -> HOLD. Otherwise stay in ACCUM.
  - HOLD: in_ready=0, out_valid=1. out_ready=1 -> IDLE; acc, cnt and ovf clear on the same edge.
- Arithmetic per accepted beat:
  - {carry, acc} <= acc + zero-extend(in_data), computed in ACC_W+1 bits.
  - On carry=1 the sum wraps modulo 2^ACC_W and ovf sets. ovf is sticky for the frame.
  - cnt increments per accepted beat and saturates at 2^CNT_W-1 (no wrap).
- Latency:
  - The last beat accepted at edge N gives out_valid=1 after edge N, holding the sum including that beat.
  - Minimum frame period is frame_beats+1 cycles: one bubble cycle in HOLD, assuming out_ready=1.
- Outputs out_sum, out_cnt and out_ovf are registered and stable throughout HOLD. They are don't-care (hold last value) when out_valid=0.
- in_valid=0 in ACCUM: state and acc are held with no timeout. in_data is ignored when not accepted.
- in_last on a single-beat frame: IDLE -> HOLD directly, cnt=1.
- Backpressure: out_ready=0 in HOLD stalls indefinitely; in_ready stays 0.

Optional Feature:
- Macro: FRAME_ACC_SATURATE_EN.
- Defined: on carry, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame. ovf still sets.
- Undefined: wrap-around arithmetic as described in Behaviour.
- Port list is identical in both builds.

Decomposition:
- Package adder_pkg holds:
  - the state encoding: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2
  - defaults DEF_ACC_W=8 and DEF_CNT_W=5
- One sub-module: ripple_add_n, parameterized width N, ports a, b, sum, cout. Built as a chain of 1-bit full-adder cells; used for the acc + in_data add.
- The FSM, counter and output registers stay in frame_accumulator.

Test Plan:
- Beats 3, 5, 9 (last on 9) with out_ready=1 -> out_sum=0x11, out_cnt=3, out_ovf=0; out_valid high for exactly 1 cycle.
- 17 beats of 0xF -> out_sum=0xFF, out_cnt=17, out_ovf=0. 18 beats of 0xF -> wrap build: out_sum=0x0E, out_ovf=1; FRAME_ACC_SATURATE_EN build: out_sum=0xFF, out_ovf=1.
- Single beat 0x7 with in_last=1 -> out_sum=0x07, out_cnt=1 one cycle later. A second frame issued back-to-back starts clean: 0x2 -> out_sum=0x02.
- out_ready held 0 for 5 cycles in HOLD -> out_valid, out_sum and out_cnt stable; in_ready=0; in_valid beats are not accepted. out_ready=1 -> IDLE next cycle.
- rst pulsed after 2 beats (0x4, 0x4), then frame 0x1 (last) -> out_sum=0x01, out_cnt=1. All outputs read 0 during reset.
- 40 beats of 0x0 -> out_cnt saturates at 31, out_sum=0x00, out_ovf=0.
